operand_loader: RTL and testbench
=================================

Name: operand_loader

Overview:
- Parametrised byte-serial operand entry and result viewer for the board ALU demos.
- User sets DATA_W switches and presses a step button; each press stores one byte into N_OPS operands of WORDS bytes each, LSB byte first.
- After the last byte the block runs a start/done handshake with an external arithmetic unit, latches the result and pages through it byte by byte for the 7-seg decoders.
- Adds over the previous loader: a back button, operand count and widths as parameters, ALU handshake with timeout, and error display.

Parameters:
DATA_W, 8, switch/byte width
WORDS, 4, bytes per operand (1..15); OP_W = DATA_W*WORDS
N_OPS, 2, operand count (1..4)
RES_WORDS, 4, bytes in ALU result (1..15)
TIMEOUT, 1024, max cycles waiting for alu_done (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
step  in  1  raw step button level, async to clk
back  in  1  raw back button level, async to clk
data  in  DATA_W  switch value
op_bus  out  N_OPS*OP_W  operands; operand k byte j at [k*OP_W + j*DATA_W +: DATA_W]
alu_start  out  1  one-cycle start pulse
alu_done  in  1  result valid, single-cycle or level
alu_result  in  RES_WORDS*DATA_W  ALU output
disp_val  out  DATA_W  byte to display
disp_op  out  4  tag: 0xA+k operand k, 0xE result, 0xF error
disp_idx  out  4  1-based byte index
loaddata  out  1  high in LOAD
busy  out  1  high in COMPUTE
err  out  1  timeout flag

Behaviour:
- Reset values: state LOAD, cursor (op 0, byte 0), op_bus 0, result reg 0, alu_start 0, err 0, loaddata 1, busy 0, disp_op 0xA, disp_idx 1, disp_val = data.
- Buttons: 2-FF synchroniser, then rising-edge detect. The action registers on the 3rd clk edge after step first samples high. A held button gives exactly one action.
- LOAD state:
  - step: write data to the cursor byte, advance the cursor (byte, then operand).
  - step on the last byte of the last operand: write it and go to COMPUTE.
  - back: decrement cursor without clearing the byte; at (0,0) back is ignored.
  - step and back in the same cycle: ignored.
  - disp_val = live data; disp_op = 0xA+op; disp_idx = byte+1.
- COMPUTE state:
  - alu_start is high for exactly the first cycle in COMPUTE.
  - alu_done is sampled from the second cycle on. On done, latch alu_result, err=0, go to SHOW page 0.
  - A cycle counter that reaches TIMEOUT without done clears the result reg, sets err=1 and goes to SHOW.
  - Buttons are ignored. busy=1, disp_val=0, disp_op=0xE, disp_idx=0.
- SHOW state:
  - step: page+1, wrapping RES_WORDS-1 -> 0. back: page-1, wrapping 0 -> RES_WORDS-1.
  - step and back together: clear operands, result and err, go to LOAD at (0,0).
  - disp_val = result byte[page]; disp_op = err ? 0xF : 0xE; disp_idx = page+1.
- op_bus reflects stored bytes continuously and holds its value through COMPUTE and SHOW.
- Reset asserted in any state, including mid-COMPUTE, returns everything to reset values immediately. alu_start drops asynchronously.

Decomposition:
- Package loader_pkg: state enum {LOAD, COMPUTE, SHOW}; tag constants TAG_OP_BASE=4'hA, TAG_RES=4'hE, TAG_ERR=4'hF.
- Sub-module btn_pulse (sync + edge detect), instantiated for step and back.

Test Plan:
- Defaults, 8 steps loading A=0x00000003 then B=0x00000005 (LSB first); ALU model returns 0x0000000F 4 cycles after start -> op_bus=0x0000000500000003, one alu_start pulse, then SHOW with disp_op=0xE, idx=1, val=0x0F. Three steps give idx 2,3,4 with val 0x00; a 4th step wraps to idx 1.
- LOAD 0x11, 0x22, 0x33, then back, then load 0x44 -> A byte2 = 0x44, cursor at A byte3, disp_idx=4.
- back at (0,0) and step+back together in LOAD -> no cursor change, op_bus unchanged.
- TIMEOUT=16, ALU never answers -> SHOW after 16 COMPUTE cycles with err=1, disp_op=0xF, disp_val=0.
- rst pulse 3 cycles into COMPUTE -> alu_start 0, state LOAD, op_bus 0, disp_op 0xA, disp_idx 1. Step held 100 cycles -> exactly one byte stored.
- In SHOW page 2, step+back together -> LOAD at (0,0), op_bus 0, err 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and display tag constants for the operand loader.
package loader_pkg;

  // Top-level operating modes of the loader.
  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    SHOW
  } state_e;

  // Tags shown on the 7-seg operand/result selector digit.
  localparam logic [3:0] TAG_OP_BASE = 4'hA;
  localparam logic [3:0] TAG_RES     = 4'hE;
  localparam logic [3:0] TAG_ERR     = 4'hF;

endpackage

// File: rtl/btn_pulse.sv
// Turns a raw, asynchronous push-button level into a single-cycle pulse.
module btn_pulse (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-flop synchroniser followed by a delayed copy for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // High for exactly one cycle per press, however long the button is held.
  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/operand_loader.sv
// Byte-serial operand entry, ALU start/done handshake and result paging
// for the board ALU demos.
module operand_loader
  import loader_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int WORDS     = 4,
  parameter int N_OPS     = 2,
  parameter int RES_WORDS = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          step,
  input  logic                          back,
  input  logic [DATA_W-1:0]             data,
  output logic [N_OPS*DATA_W*WORDS-1:0] op_bus,
  output logic                          alu_start,
  input  logic                          alu_done,
  input  logic [RES_WORDS*DATA_W-1:0]   alu_result,
  output logic [DATA_W-1:0]             disp_val,
  output logic [3:0]                    disp_op,
  output logic [3:0]                    disp_idx,
  output logic                          loaddata,
  output logic                          busy,
  output logic                          err
);

  localparam int OP_W  = DATA_W * WORDS;
  localparam int BUS_W = N_OPS * OP_W;
  localparam int RES_W = RES_WORDS * DATA_W;
  localparam int OPI_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  state_e             state_q;
  logic [OPI_W-1:0]   opIdx_q;
  logic [3:0]         byteIdx_q;
  logic [3:0]         page_q;
  logic [BUS_W-1:0]   opBus_q;
  logic [BUS_W-1:0]   opBus_d;
  logic [RES_W-1:0]   result_q;
  logic               err_q;
  logic               aluStart_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               stepPulse;
  logic               backPulse;
  logic               stepAct;
  logic               backAct;
  logic               bothAct;
  logic               lastByte;
  logic               lastOp;
  logic [DATA_W-1:0]  resByte;

  btn_pulse u_stepPulse (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (step),
    .pulse_o (stepPulse)
  );

  btn_pulse u_backPulse (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (back),
    .pulse_o (backPulse)
  );

  // A simultaneous step and back is a distinct command, never a step or a back.
  assign stepAct  = stepPulse & ~backPulse;
  assign backAct  = backPulse & ~stepPulse;
  assign bothAct  = stepPulse & backPulse;
  assign lastByte = (byteIdx_q == 4'(WORDS - 1));
  assign lastOp   = (opIdx_q == OPI_W'(N_OPS - 1));

  // Image of the operand bus with the switch byte written at the cursor.
  always_comb begin
    opBus_d = opBus_q;
    for (int k = 0; k < N_OPS; k++) begin
      for (int j = 0; j < WORDS; j++) begin
        if (opIdx_q == OPI_W'(k) && byteIdx_q == 4'(j)) begin
          opBus_d[k*OP_W + j*DATA_W +: DATA_W] = data;
        end
      end
    end
  end

  // Result byte selected by the current display page.
  always_comb begin
    resByte = '0;
    for (int p = 0; p < RES_WORDS; p++) begin
      if (page_q == 4'(p)) begin
        resByte = result_q[p*DATA_W +: DATA_W];
      end
    end
  end

  // Main controller: operand entry, ALU handshake with timeout, result paging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      opIdx_q    <= '0;
      byteIdx_q  <= '0;
      page_q     <= '0;
      opBus_q    <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      aluStart_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      aluStart_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (stepAct) begin
            opBus_q <= opBus_d;
            if (lastByte && lastOp) begin
              state_q    <= COMPUTE;
              aluStart_q <= 1'b1;
              cnt_q      <= '0;
            end else if (lastByte) begin
              byteIdx_q <= '0;
              opIdx_q   <= opIdx_q + OPI_W'(1);
            end else begin
              byteIdx_q <= byteIdx_q + 4'd1;
            end
          end else if (backAct) begin
            if (byteIdx_q != 4'd0) begin
              byteIdx_q <= byteIdx_q - 4'd1;
            end else if (opIdx_q != '0) begin
              opIdx_q   <= opIdx_q - OPI_W'(1);
              byteIdx_q <= 4'(WORDS - 1);
            end
          end
        end
        COMPUTE: begin
          if (cnt_q != '0 && alu_done) begin
            result_q <= alu_result;
            err_q    <= 1'b0;
            page_q   <= '0;
            state_q  <= SHOW;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            result_q <= '0;
            err_q    <= 1'b1;
            page_q   <= '0;
            state_q  <= SHOW;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SHOW: begin
          if (bothAct) begin
            opBus_q   <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            opIdx_q   <= '0;
            byteIdx_q <= '0;
            state_q   <= LOAD;
          end else if (stepAct) begin
            page_q <= (page_q == 4'(RES_WORDS - 1)) ? 4'd0 : page_q + 4'd1;
          end else if (backAct) begin
            page_q <= (page_q == 4'd0) ? 4'(RES_WORDS - 1) : page_q - 4'd1;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  // Seven-segment view: live switches while loading, blank while computing,
  // selected result byte afterwards.
  always_comb begin
    disp_val = '0;
    disp_op  = TAG_OP_BASE;
    disp_idx = 4'd1;
    case (state_q)
      LOAD: begin
        disp_val = data;
        disp_op  = TAG_OP_BASE + 4'(opIdx_q);
        disp_idx = byteIdx_q + 4'd1;
      end
      COMPUTE: begin
        disp_val = '0;
        disp_op  = TAG_RES;
        disp_idx = 4'd0;
      end
      SHOW: begin
        disp_val = resByte;
        disp_op  = err_q ? TAG_ERR : TAG_RES;
        disp_idx = page_q + 4'd1;
      end
      default: ;
    endcase
  end

  assign op_bus    = opBus_q;
  assign alu_start = aluStart_q;
  assign loaddata  = (state_q == LOAD);
  assign busy      = (state_q == COMPUTE);
  assign err       = err_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader against a linear-buffer reference model.
module tb_operand_loader;

  localparam int DATA_W    = 8;
  localparam int WORDS     = 4;
  localparam int N_OPS     = 2;
  localparam int RES_WORDS = 4;
  localparam int TIMEOUT   = 16;
  localparam int NB        = N_OPS * WORDS;
  localparam int BUS_W     = NB * DATA_W;
  localparam int RES_W     = RES_WORDS * DATA_W;
  localparam int M_LOAD    = 0;
  localparam int M_COMPUTE = 1;
  localparam int M_SHOW    = 2;
  localparam int K_STEP    = 0;
  localparam int K_BACK    = 1;
  localparam int K_BOTH    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              step = 1'b0;
  logic              back = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic [BUS_W-1:0]  op_bus;
  logic              alu_start;
  logic              alu_done = 1'b0;
  logic [RES_W-1:0]  alu_result = '0;
  logic [DATA_W-1:0] disp_val;
  logic [3:0]        disp_op;
  logic [3:0]        disp_idx;
  logic              loaddata;
  logic              busy;
  logic              err;

  int checks = 0;
  int failures = 0;

  // Reference model: operands as one flat byte buffer, cursor as a linear position.
  logic [DATA_W-1:0] mdlOps [NB];
  int                mdlPos;
  int                mdlMode;
  logic [RES_W-1:0]  mdlRes;
  logic              mdlErr;
  int                mdlPage;

  // ALU stand-in: answers three cycles after it sees start, if enabled.
  int                aluDelay = 0;
  int                startSeen = 0;
  bit                aluEnable = 1'b0;

  operand_loader #(
    .DATA_W    (DATA_W),
    .WORDS     (WORDS),
    .N_OPS     (N_OPS),
    .RES_WORDS (RES_WORDS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .step       (step),
    .back       (back),
    .data       (data),
    .op_bus     (op_bus),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .disp_val   (disp_val),
    .disp_op    (disp_op),
    .disp_idx   (disp_idx),
    .loaddata   (loaddata),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    alu_done = 1'b0;
    if (alu_start) begin
      startSeen++;
      aluDelay = 3;
    end else if (aluDelay > 0) begin
      aluDelay--;
      if (aluDelay == 0 && aluEnable) alu_done = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BUS_W-1:0] modelBus();
    logic [BUS_W-1:0] b;
    b = '0;
    for (int i = 0; i < NB; i++) b[i*DATA_W +: DATA_W] = mdlOps[i];
    return b;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NB; i++) mdlOps[i] = '0;
    mdlPos  = 0;
    mdlMode = M_LOAD;
    mdlRes  = '0;
    mdlErr  = 1'b0;
    mdlPage = 0;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".bus"}, op_bus, modelBus());
    checkOutput({tag, ".loaddata"}, loaddata, 128'(mdlMode == M_LOAD));
    checkOutput({tag, ".busy"}, busy, 128'(mdlMode == M_COMPUTE));
    checkOutput({tag, ".err"}, err, mdlErr);
    if (mdlMode == M_LOAD) begin
      checkOutput({tag, ".val"}, disp_val, data);
      checkOutput({tag, ".op"}, disp_op, 128'(10 + mdlPos / WORDS));
      checkOutput({tag, ".idx"}, disp_idx, 128'(mdlPos % WORDS + 1));
    end else begin
      checkOutput({tag, ".val"}, disp_val, 128'((mdlRes >> (mdlPage * DATA_W)) & 8'hFF));
      checkOutput({tag, ".op"}, disp_op, mdlErr ? 128'hF : 128'hE);
      checkOutput({tag, ".idx"}, disp_idx, 128'(mdlPage + 1));
    end
  endtask

  // Press a button (or both), apply the effect to the model; checks unless
  // the press started a computation, which the caller follows instead.
  task automatic applyStimulus(input int kind, input logic [DATA_W-1:0] value);
    data = value;
    step = (kind == K_STEP || kind == K_BOTH);
    back = (kind == K_BACK || kind == K_BOTH);
    repeat (3) tick();
    step = 1'b0;
    back = 1'b0;
    if (mdlMode == M_LOAD) begin
      if (kind == K_STEP) begin
        mdlOps[mdlPos] = value;
        if (mdlPos == NB - 1) mdlMode = M_COMPUTE;
        else mdlPos++;
      end else if (kind == K_BACK && mdlPos > 0) begin
        mdlPos--;
      end
    end else if (mdlMode == M_SHOW) begin
      if (kind == K_STEP) mdlPage = (mdlPage + 1) % RES_WORDS;
      else if (kind == K_BACK) mdlPage = (mdlPage + RES_WORDS - 1) % RES_WORDS;
      else modelReset();
    end
    if (mdlMode != M_COMPUTE) begin
      repeat (2) tick();
      checkState($sformatf("press%0d", kind));
    end
  endtask

  // Follow one computation from its first cycle through to the result page.
  task automatic runCompute(input string tag, input int expCycles, input int startsBefore);
    int n;
    checkOutput({tag, ".start"}, alu_start, 1'b1);
    checkOutput({tag, ".busy"}, busy, 1'b1);
    checkOutput({tag, ".cval"}, disp_val, 0);
    checkOutput({tag, ".cop"}, disp_op, 4'hE);
    checkOutput({tag, ".cidx"}, disp_idx, 0);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    checkOutput({tag, ".cycles"}, n, expCycles);
    checkOutput({tag, ".starts"}, startSeen - startsBefore, 1);
    mdlMode = M_SHOW;
    mdlPage = 0;
    mdlErr  = !aluEnable;
    mdlRes  = aluEnable ? alu_result : '0;
    checkState({tag, ".show"});
  endtask

  task automatic loadRandom();
    int guard;
    guard = 0;
    while (mdlMode == M_LOAD && guard < 300) begin
      guard++;
      case ($urandom_range(0, 5))
        0: applyStimulus(K_BACK, 8'($urandom));
        1: applyStimulus(K_BOTH, 8'($urandom));
        default: applyStimulus(K_STEP, 8'($urandom));
      endcase
    end
    checkOutput("rand.reachedCompute", mdlMode, M_COMPUTE);
  endtask

  initial begin
    logic [7:0] planBytes [8];
    int s0;
    logic [7:0] held;

    // Reset state.
    modelReset();
    data = 8'h5A;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checkOutput("reset.start", alu_start, 1'b0);
    checkState("reset");

    // Load A=3, B=5 LSB first; ALU answers 0x0F.
    planBytes = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    aluEnable = 1'b1;
    alu_result = 32'h0000_000F;
    s0 = startSeen;
    for (int i = 0; i < 8; i++) applyStimulus(K_STEP, planBytes[i]);
    runCompute("plan", 4, s0);
    checkOutput("plan.bus", op_bus, 64'h0000_0005_0000_0003);
    checkOutput("plan.val0", disp_val, 8'h0F);
    for (int i = 0; i < 4; i++) applyStimulus(K_STEP, 8'h00);
    checkOutput("plan.wrapIdx", disp_idx, 1);
    applyStimulus(K_BACK, 8'h00);
    checkOutput("plan.backWrap", disp_idx, 4);
    applyStimulus(K_STEP, 8'h00);
    applyStimulus(K_STEP, 8'h00);
    applyStimulus(K_STEP, 8'h00);
    checkOutput("plan.page2", disp_idx, 3);
    applyStimulus(K_BOTH, 8'h00);
    checkOutput("clear.bus", op_bus, 0);
    checkOutput("clear.err", err, 1'b0);

    // Overwrite via back.
    applyStimulus(K_STEP, 8'h11);
    applyStimulus(K_STEP, 8'h22);
    applyStimulus(K_STEP, 8'h33);
    applyStimulus(K_BACK, 8'h00);
    applyStimulus(K_STEP, 8'h44);
    checkOutput("back.byte2", op_bus[23:16], 8'h44);
    checkOutput("back.idx", disp_idx, 4);

    // Back to (0,0), then back and step+back that must do nothing.
    repeat (3) applyStimulus(K_BACK, 8'h00);
    applyStimulus(K_BACK, 8'h77);
    applyStimulus(K_BOTH, 8'h66);

    // ALU silent: timeout path.
    aluEnable = 1'b0;
    alu_result = 32'hDEAD_BEEF;
    s0 = startSeen;
    loadRandom();
    runCompute("timeout", TIMEOUT, s0);
    checkOutput("timeout.err", err, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(K_STEP, 8'h00);
    applyStimulus(K_BACK, 8'h00);
    applyStimulus(K_BOTH, 8'h00);

    // Random operands and result.
    aluEnable = 1'b1;
    alu_result = RES_W'($urandom);
    s0 = startSeen;
    loadRandom();
    runCompute("random", 4, s0);
    for (int i = 0; i < 6; i++) applyStimulus(($urandom_range(0, 1) == 0) ? K_STEP : K_BACK, 8'h00);
    applyStimulus(K_BOTH, 8'h00);

    // Reset three cycles into COMPUTE.
    aluEnable = 1'b0;
    loadRandom();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst.start", alu_start, 1'b0);
    checkOutput("midrst.busy", busy, 1'b0);
    checkOutput("midrst.loaddata", loaddata, 1'b1);
    checkOutput("midrst.bus", op_bus, 0);
    checkOutput("midrst.op", disp_op, 4'hA);
    checkOutput("midrst.idx", disp_idx, 1);
    modelReset();
    tick();
    rst = 1'b0;
    tick();
    checkState("midrst");

    // Step held for 100 cycles stores exactly one byte.
    held = 8'($urandom);
    data = held;
    step = 1'b1;
    repeat (100) tick();
    step = 1'b0;
    repeat (2) tick();
    mdlOps[0] = held;
    mdlPos = 1;
    checkState("held");
    checkOutput("held.idx", disp_idx, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
